// File: rtl/dch_dcd_ssd_pkg.sv
// rtl/dch_dcd_ssd_pkg.sv - shared limits and seven-segment patterns for dch_dcd_ssd
package dch_dcd_ssd_pkg;

  localparam logic [3:0] HEX_MAX = 4'hF;
  localparam logic [3:0] BCD_MAX = 4'h9;

  // Active-low cathode patterns, bit6 = g ... bit0 = a
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = SEG_0;
      4'h1: seg_decode = SEG_1;
      4'h2: seg_decode = SEG_2;
      4'h3: seg_decode = SEG_3;
      4'h4: seg_decode = SEG_4;
      4'h5: seg_decode = SEG_5;
      4'h6: seg_decode = SEG_6;
      4'h7: seg_decode = SEG_7;
      4'h8: seg_decode = SEG_8;
      4'h9: seg_decode = SEG_9;
      4'hA: seg_decode = SEG_A;
      4'hB: seg_decode = SEG_B;
      4'hC: seg_decode = SEG_C;
      4'hD: seg_decode = SEG_D;
      4'hE: seg_decode = SEG_E;
      default: seg_decode = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/dch_dcd_ssd_downcounter_4b.sv
// rtl/dch_dcd_ssd_downcounter_4b.sv - 4-bit wrapping down-counter with load clamp and borrow pulse
module downcounter_4b #(
  parameter logic [3:0] MAX = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       en,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] cnt,
  output logic       bor
);

  logic [3:0] r_cnt;
  logic       r_bor;
  logic [3:0] w_ld_clamp;

  // A full-range counter needs no clamp; a comparison against 15 would be constant
  generate
    if (MAX == 4'hF) begin : g_full
      assign w_ld_clamp = ld_val;
    end else begin : g_clamp
      assign w_ld_clamp = (ld_val > MAX) ? MAX : ld_val;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 4'h0;
      r_bor <= 1'b0;
    end else if (ld) begin
      r_cnt <= w_ld_clamp;
      r_bor <= 1'b0;
    end else if (tick && en) begin
      if (r_cnt == 4'h0) begin
        r_cnt <= MAX;
        r_bor <= 1'b1;
      end else begin
        r_cnt <= r_cnt - 4'h1;
        r_bor <= 1'b0;
      end
    end else begin
      r_bor <= 1'b0;
    end
  end

  assign cnt = r_cnt;
  assign bor = r_bor;

endmodule

// File: rtl/dch_dcd_ssd.sv
// rtl/dch_dcd_ssd.sv - dual hex/BCD down-counter driving one active-low seven-segment digit
module dch_dcd_ssd
  import dch_dcd_ssd_pkg::*;
#(
  parameter int DIV_MAX = 100_000_000,
  parameter int DIV_W   = 27
) (
  input  logic       dch_dcd_ssd_clk,
  input  logic       dch_dcd_ssd_rst,
  input  logic       dch_dcd_ssd_hex_en,
  input  logic       dch_dcd_ssd_bcd_en,
  input  logic       dch_dcd_ssd_ld,
  input  logic [3:0] dch_dcd_ssd_ld_val,
  input  logic       dch_dcd_ssd_sel,
  output logic       dch_dcd_ssd_rst_led,
  output logic       dch_dcd_ssd_hex_en_led,
  output logic       dch_dcd_ssd_bcd_en_led,
  output logic       dch_dcd_ssd_sel_led,
  output logic       dch_dcd_ssd_hex_bor,
  output logic       dch_dcd_ssd_bcd_bor,
  output logic [6:0] dch_dcd_ssd_cc,
  output logic       dch_dcd_ssd_an_on,
  output logic [6:0] dch_dcd_ssd_an_off
);

  logic [DIV_W-1:0] r_div;
  logic             w_tick;
  logic [3:0]       w_hex_cnt;
  logic [3:0]       w_bcd_cnt;

  // Free-running divider; the tick is a clock enable, never a clock
  assign w_tick = (r_div == DIV_W'(DIV_MAX - 1));

  always_ff @(posedge dch_dcd_ssd_clk or posedge dch_dcd_ssd_rst) begin
    if (dch_dcd_ssd_rst) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  downcounter_4b #(.MAX(HEX_MAX)) u_hex (
    .clk    (dch_dcd_ssd_clk),
    .rst    (dch_dcd_ssd_rst),
    .tick   (w_tick),
    .en     (dch_dcd_ssd_hex_en),
    .ld     (dch_dcd_ssd_ld),
    .ld_val (dch_dcd_ssd_ld_val),
    .cnt    (w_hex_cnt),
    .bor    (dch_dcd_ssd_hex_bor)
  );

  downcounter_4b #(.MAX(BCD_MAX)) u_bcd (
    .clk    (dch_dcd_ssd_clk),
    .rst    (dch_dcd_ssd_rst),
    .tick   (w_tick),
    .en     (dch_dcd_ssd_bcd_en),
    .ld     (dch_dcd_ssd_ld),
    .ld_val (dch_dcd_ssd_ld_val),
    .cnt    (w_bcd_cnt),
    .bor    (dch_dcd_ssd_bcd_bor)
  );

  assign dch_dcd_ssd_cc = seg_decode(dch_dcd_ssd_sel ? w_bcd_cnt : w_hex_cnt);

  assign dch_dcd_ssd_rst_led    = dch_dcd_ssd_rst;
  assign dch_dcd_ssd_hex_en_led = dch_dcd_ssd_hex_en;
  assign dch_dcd_ssd_bcd_en_led = dch_dcd_ssd_bcd_en;
  assign dch_dcd_ssd_sel_led    = dch_dcd_ssd_sel;
  assign dch_dcd_ssd_an_on      = 1'b0;
  assign dch_dcd_ssd_an_off     = 7'b1111111;

endmodule

// File: tb/tb_dch_dcd_ssd.sv
// tb/tb_dch_dcd_ssd.sv - self-checking bench for dch_dcd_ssd
module tb_dch_dcd_ssd;

  localparam int DIV_MAX = 4;
  localparam int DIV_W   = 3;

  logic       clk = 1'b0;
  logic       rst, hex_en, bcd_en, ld, sel;
  logic [3:0] ld_val;
  logic       rst_led, hex_en_led, bcd_en_led, sel_led;
  logic       hex_bor, bcd_bor, an_on;
  logic [6:0] cc, an_off;

  dch_dcd_ssd #(.DIV_MAX(DIV_MAX), .DIV_W(DIV_W)) dut (
    .dch_dcd_ssd_clk        (clk),
    .dch_dcd_ssd_rst        (rst),
    .dch_dcd_ssd_hex_en     (hex_en),
    .dch_dcd_ssd_bcd_en     (bcd_en),
    .dch_dcd_ssd_ld         (ld),
    .dch_dcd_ssd_ld_val     (ld_val),
    .dch_dcd_ssd_sel        (sel),
    .dch_dcd_ssd_rst_led    (rst_led),
    .dch_dcd_ssd_hex_en_led (hex_en_led),
    .dch_dcd_ssd_bcd_en_led (bcd_en_led),
    .dch_dcd_ssd_sel_led    (sel_led),
    .dch_dcd_ssd_hex_bor    (hex_bor),
    .dch_dcd_ssd_bcd_bor    (bcd_bor),
    .dch_dcd_ssd_cc         (cc),
    .dch_dcd_ssd_an_on      (an_on),
    .dch_dcd_ssd_an_off     (an_off)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [3:0] ld_val;
    logic       hex_en;
    logic       bcd_en;
    logic       sel;
    int         cycles;
    logic [3:0] exp_hex;
    logic [3:0] exp_bcd;
    int         exp_hbor;
    int         exp_bbor;
    int         exp_both;
  } phase_t;

  typedef struct {
    logic [3:0] hex;
    logic [3:0] bcd;
    logic       hbor;
    logic       bbor;
  } exp_t;

  phase_t     tbl [12];
  exp_t       sb_q [$];
  logic [6:0] seg_tab [16];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         hb_cnt, bb_cnt, both_cnt;
  int         cyc = 0;
  int         last_tick = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: advances on the same edges as the DUT and queues the
  // outputs that should be visible for the following cycle
  logic [3:0] m_hex, m_bcd;
  logic       m_hb, m_bb, m_tick;
  int         m_div;
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_div = 0; m_hex = 4'h0; m_bcd = 4'h0; m_hb = 1'b0; m_bb = 1'b0;
    end else begin
      m_tick = (m_div == DIV_MAX - 1);
      m_div  = m_tick ? 0 : m_div + 1;
      m_hb = 1'b0;
      m_bb = 1'b0;
      if (ld) begin
        m_hex = ld_val;
        m_bcd = (ld_val > 4'd9) ? 4'd9 : ld_val;
      end else begin
        if (m_tick && hex_en) begin
          if (m_hex == 4'h0) begin m_hex = 4'hF; m_hb = 1'b1; end
          else m_hex = m_hex - 4'h1;
        end
        if (m_tick && bcd_en) begin
          if (m_bcd == 4'h0) begin m_bcd = 4'h9; m_bb = 1'b1; end
          else m_bcd = m_bcd - 4'h1;
        end
      end
      sb_q.push_back('{m_hex, m_bcd, m_hb, m_bb});
    end
  end

  exp_t e;
  initial forever begin
    @(negedge clk);
    cyc++;
    check("an_on", {31'b0, an_on}, 32'h0);
    check("an_off", {25'b0, an_off}, 32'h7F);
    if (rst) begin
      sb_q.delete();
      last_tick = -1;
      check("rst_cc", {25'b0, cc}, {25'b0, seg_tab[0]});
      check("rst_hbor", {31'b0, hex_bor}, 32'h0);
      check("rst_bbor", {31'b0, bcd_bor}, 32'h0);
    end else begin
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_cc", {25'b0, cc}, {25'b0, seg_tab[sel ? e.bcd : e.hex]});
        check("sb_hbor", {31'b0, hex_bor}, {31'b0, e.hbor});
        check("sb_bbor", {31'b0, bcd_bor}, {31'b0, e.bbor});
      end
      if (hex_bor) hb_cnt++;
      if (bcd_bor) bb_cnt++;
      if (hex_bor && bcd_bor) both_cnt++;
      if (dut.w_tick) begin
        if (last_tick >= 0) check("tick_gap", cyc - last_tick, DIV_MAX);
        last_tick = cyc;
      end
    end
  end

  task automatic apply(input logic l, input logic [3:0] v, input logic he,
                       input logic be, input logic s);
    ld = l; ld_val = v; hex_en = he; bcd_en = be; sel = s;
    #1;
    check("rst_led", {31'b0, rst_led}, {31'b0, rst});
    check("hex_en_led", {31'b0, hex_en_led}, {31'b0, he});
    check("bcd_en_led", {31'b0, bcd_en_led}, {31'b0, be});
    check("sel_led", {31'b0, sel_led}, {31'b0, s});
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  int exp_bcd_val;
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
    seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
    seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
    seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
    seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
    seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

    //           ld  val   he  be  sel cyc hex   bcd   hb bb both
    tbl[0]  = '{0, 4'h0, 1, 1, 0, 4,  4'hF, 4'h9, 1, 1, 1};
    tbl[1]  = '{0, 4'h0, 1, 1, 0, 4,  4'hE, 4'h8, 0, 0, 0};
    tbl[2]  = '{0, 4'h0, 0, 1, 1, 80, 4'hE, 4'h8, 0, 2, 0};
    tbl[3]  = '{1, 4'hC, 1, 1, 0, 1,  4'hC, 4'h9, 0, 0, 0};
    tbl[4]  = '{1, 4'hC, 1, 1, 1, 4,  4'hC, 4'h9, 0, 0, 0};
    tbl[5]  = '{1, 4'h0, 1, 1, 0, 1,  4'h0, 4'h0, 0, 0, 0};
    tbl[6]  = '{0, 4'h0, 1, 1, 0, 4,  4'hF, 4'h9, 1, 1, 1};
    tbl[7]  = '{0, 4'h0, 1, 0, 1, 8,  4'hD, 4'h9, 0, 0, 0};
    tbl[8]  = '{1, 4'h5, 0, 0, 0, 1,  4'h5, 4'h5, 0, 0, 0};
    tbl[9]  = '{0, 4'h0, 1, 1, 0, 24, 4'hF, 4'h9, 1, 1, 1};
    tbl[10] = '{1, 4'hA, 0, 0, 1, 1,  4'hA, 4'h9, 0, 0, 0};
    tbl[11] = '{0, 4'h0, 0, 0, 0, 8,  4'hA, 4'h9, 0, 0, 0};

    rst = 1'b1; ld = 1'b0; ld_val = 4'h0; hex_en = 1'b0; bcd_en = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #2;

    // Table phases: inputs held for a whole number of ticks, then final counts read back through both selects
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].ld, tbl[i].ld_val, tbl[i].hex_en, tbl[i].bcd_en, tbl[i].sel);
      hb_cnt = 0; bb_cnt = 0; both_cnt = 0;
      repeat (tbl[i].cycles) @(posedge clk);
      @(negedge clk);
      #1;
      check($sformatf("p%0d_hbor_cnt", i), hb_cnt, tbl[i].exp_hbor);
      check($sformatf("p%0d_bbor_cnt", i), bb_cnt, tbl[i].exp_bbor);
      check($sformatf("p%0d_both_cnt", i), both_cnt, tbl[i].exp_both);
      sel = 1'b0;
      #1 check($sformatf("p%0d_hex_cc", i), {25'b0, cc}, {25'b0, seg_tab[tbl[i].exp_hex]});
      sel = 1'b1;
      #1 check($sformatf("p%0d_bcd_cc", i), {25'b0, cc}, {25'b0, seg_tab[tbl[i].exp_bcd]});
    end

    // BCD sweep from reset: 9, 8, ... 0, 9 over eleven ticks
    rst = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b0;
    apply(1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
    bb_cnt = 0;
    for (int k = 1; k <= 11; k++) begin
      repeat (DIV_MAX) @(posedge clk);
      @(negedge clk);
      #1;
      exp_bcd_val = (10 - (k % 10)) % 10;
      check($sformatf("bcd_seq_%0d", k), {25'b0, cc}, {25'b0, seg_tab[exp_bcd_val]});
    end
    check("bcd_seq_bor_cnt", bb_cnt, 2);

    // Asynchronous reset between edges while counting
    apply(1'b1, 4'h7, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #2 apply(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_hex_cc", {25'b0, cc}, {25'b0, seg_tab[0]});
    check("async_div", {29'b0, dut.r_div}, 32'h0);
    check("async_hbor", {31'b0, hex_bor}, 32'h0);
    check("async_bbor", {31'b0, bcd_bor}, 32'h0);
    check("async_rst_led", {31'b0, rst_led}, 32'h1);
    @(negedge clk);
    #1 sel = 1'b1;
    #1 check("async_bcd_cc", {25'b0, cc}, {25'b0, seg_tab[0]});
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
